// File: rtl/pipe_stage_reg.sv
// Configurable inter-stage pipeline register: valid/ready handshake, optional 2-entry skid, flush, bubble zeroing, stall counter.
// Latency 1 cycle; in_ready is registered when SKID=1, else combinational from out_ready.
module pipe_stage_reg #(
  parameter int CTRL_W      = 4,
  parameter int DATA_W      = 133,
  parameter int SKID        = 1,
  parameter int ZERO_BUBBLE = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                rdy_q, rdy_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                in_xfer, out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign data_o    = main_data_q;
  assign ctrl_o    = (ZERO_BUBBLE != 0 && !out_valid) ? '0 : main_ctrl_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (SKID != 0) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
          end else if (in_xfer) begin
            skid_ctrl_d = ctrl_i;
            skid_data_d = data_i;
            state_d     = ST_TWO;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain path can fire
          if (out_xfer) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end else begin
      if (in_xfer) begin
        main_ctrl_d = ctrl_i;
        main_data_d = data_i;
        state_d     = ST_ONE;
      end else if (out_xfer) begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_comb begin
    rdy_d = (state_d != ST_TWO);
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      rdy_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      rdy_q       <= rdy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: default build (a_), 4-bit counter build (b_), and SKID=0/ZERO_BUBBLE=0 build (c_) share one input stream.
module tb_pipe_stage_reg;

  logic         clk;
  logic         rstn;
  logic         flush;
  logic         in_valid;
  logic [3:0]   ctrl_i;
  logic [132:0] data_i;
  logic         out_ready;
  logic         stall_clr;

  logic         a_in_ready, a_out_valid;
  logic [3:0]   a_ctrl_o;
  logic [132:0] a_data_o;
  logic [15:0]  a_stall_cnt;

  logic         b_in_ready, b_out_valid;
  logic [3:0]   b_ctrl_o;
  logic [132:0] b_data_o;
  logic [3:0]   b_stall_cnt;

  logic         c_in_ready, c_out_valid;
  logic [3:0]   c_ctrl_o;
  logic [132:0] c_data_o;
  logic [15:0]  c_stall_cnt;

  int checks;
  int failures;

  pipe_stage_reg u_a (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .ctrl_i(ctrl_i), .data_i(data_i), .out_valid(a_out_valid), .out_ready(out_ready),
    .ctrl_o(a_ctrl_o), .data_o(a_data_o), .stall_cnt(a_stall_cnt), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.CNT_W(4)) u_b (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .ctrl_i(ctrl_i), .data_i(data_i), .out_valid(b_out_valid), .out_ready(out_ready),
    .ctrl_o(b_ctrl_o), .data_o(b_data_o), .stall_cnt(b_stall_cnt), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.SKID(0), .ZERO_BUBBLE(0)) u_c (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .ctrl_i(ctrl_i), .data_i(data_i), .out_valid(c_out_valid), .out_ready(out_ready),
    .ctrl_o(c_ctrl_o), .data_o(c_data_o), .stall_cnt(c_stall_cnt), .stall_clr(stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [132:0] obs, input logic [132:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rstn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    ctrl_i    = 4'b0;
    data_i    = '0;
    out_ready = 1'b0;
    stall_clr = 1'b0;

    // reset state
    #1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_ctrl_o", a_ctrl_o, 0);
    check("rst_data_o", a_data_o, 0);
    check("rst_stall_cnt", a_stall_cnt, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("rdy_after_rst", a_in_ready, 1);

    // stream five words at full throughput
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ctrl_i    = 4'b1011;
    for (int k = 1; k <= 5; k++) begin
      data_i = 133'(k);
      tick();
      check("stream_valid", a_out_valid, 1);
      check("stream_data", a_data_o, 133'(k));
      check("stream_ctrl", a_ctrl_o, 4'b1011);
      check("stream_s0_data", c_data_o, 133'(k));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", a_out_valid, 0);
    check("bubble_ctrl_zero", a_ctrl_o, 0);
    check("stream_stall", a_stall_cnt, 0);
    check("s0_bubble_ctrl_hold", c_ctrl_o, 4'b1011);

    // backpressure fills the skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ctrl_i    = 4'b0001;
    data_i    = 133'hA;
    tick();
    check("bp_a_data", a_data_o, 133'hA);
    check("bp_a_rdy", a_in_ready, 1);
    check("bp_a_stall", a_stall_cnt, 0);
    data_i = 133'hB;
    tick();
    check("bp_b_rdy_low", a_in_ready, 0);
    check("bp_b_hold", a_data_o, 133'hA);
    check("bp_b_stall", a_stall_cnt, 1);
    data_i = 133'hC;
    tick();
    check("bp_c_held", a_data_o, 133'hA);
    check("bp_c_stall", a_stall_cnt, 2);
    tick();
    check("bp_c_stall2", a_stall_cnt, 3);
    out_ready = 1'b1;
    tick();
    check("bp_deliver_b", a_data_o, 133'hB);
    check("bp_rdy_back", a_in_ready, 1);
    check("bp_stall_frozen", a_stall_cnt, 3);
    tick();
    check("bp_deliver_c", a_data_o, 133'hC);
    check("bp_c_valid", a_out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("bp_empty", a_out_valid, 0);

    // flush while TWO
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_i    = 133'hE;
    tick();
    data_i = 133'hF;
    tick();
    check("fl_two_rdy", a_in_ready, 0);
    flush  = 1'b1;
    ctrl_i = 4'b1111;
    data_i = 133'hD;
    tick();
    check("fl_valid", a_out_valid, 0);
    check("fl_ctrl", a_ctrl_o, 0);
    check("fl_rdy", a_in_ready, 1);
    check("fl_stall_kept", a_stall_cnt, 5);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("fl_no_d", a_out_valid, 0);

    // flush discards an accepted input in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ctrl_i    = 4'b0010;
    data_i    = 133'h47;
    tick();
    check("fl1_one", a_data_o, 133'h47);
    flush  = 1'b1;
    data_i = 133'hD;
    tick();
    check("fl1_valid", a_out_valid, 0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("fl1_no_d", a_out_valid, 0);

    // saturation and clear
    stall_clr = 1'b1;
    tick();
    check("clr_a", a_stall_cnt, 0);
    check("clr_b", b_stall_cnt, 0);
    stall_clr = 1'b0;
    in_valid  = 1'b1;
    data_i    = 133'h48;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    check("sat_b_15", b_stall_cnt, 15);
    for (int k = 0; k < 5; k++) tick();
    check("sat_b_hold", b_stall_cnt, 15);
    check("sat_a_20", a_stall_cnt, 20);
    stall_clr = 1'b1;
    tick();
    check("sat_clr_b", b_stall_cnt, 0);
    check("sat_clr_a", a_stall_cnt, 0);
    stall_clr = 1'b0;
    tick();
    check("sat_resume_b", b_stall_cnt, 1);
    check("sat_resume_a", a_stall_cnt, 1);
    flush     = 1'b1;
    stall_clr = 1'b1;
    tick();
    check("both_valid", a_out_valid, 0);
    check("both_stall", a_stall_cnt, 0);
    flush     = 1'b0;
    stall_clr = 1'b0;

    // asynchronous reset between edges
    in_valid = 1'b1;
    data_i   = 133'h55;
    tick();
    check("ar_loaded", a_data_o, 133'h55);
    in_valid = 1'b0;
    tick();
    check("ar_stall", a_stall_cnt, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_valid", a_out_valid, 0);
    check("ar_data", a_data_o, 0);
    check("ar_stall0", a_stall_cnt, 0);
    #1;
    rstn = 1'b1;
    tick();
    check("ar_rdy", a_in_ready, 1);

    // SKID=0: combinational ready, ctrl held through bubble
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ctrl_i    = 4'b1100;
    data_i    = 133'h61;
    tick();
    check("s0_valid", c_out_valid, 1);
    check("s0_data", c_data_o, 133'h61);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("s0_rdy_low", c_in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("s0_rdy_high", c_in_ready, 1);
    tick();
    check("s0_empty", c_out_valid, 0);
    check("s0_ctrl_hold", c_ctrl_o, 4'b1100);
    out_ready = 1'b0;
    #1;
    check("s0_rdy_empty", c_in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
